// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared definitions for the PS/2 Set-2 scancode decoder: prefix bytes,
//   the ignored-code list, the Pause sequence tail, the decoder state enum
//   and the key-event record.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Keyboard status/response bytes that never start or form a key event.
  localparam int         PS2_IGNORED_NUM   = 7;
  localparam logic [55:0] PS2_IGNORED_CODES =
    {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

  // Bytes expected after the leading E1 of Pause, index 1 in the top byte.
  localparam logic [55:0] PS2_PAUSE_TAIL =
    {8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  localparam int PS2_EV_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } dec_state_e;

  typedef struct packed {
    logic       extended;
    logic       released;
    logic [7:0] code;
  } ps2_event_t;

  function automatic ps2_event_t make_event(input logic ext, input logic rel,
                                            input logic [7:0] code);
    ps2_event_t ev;
    ev.extended = ext;
    ev.released = rel;
    ev.code     = code;
    return ev;
  endfunction

  function automatic logic is_ignored(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < PS2_IGNORED_NUM; i++) begin
      if (b == PS2_IGNORED_CODES[i*8 +: 8]) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  // Expected Pause byte for index 1..7 (index 1 is the first byte after E1).
  function automatic logic [7:0] pause_expected(input logic [2:0] idx);
    int unsigned pos;
    pos = (32'd7 - 32'(idx)) * 32'd8;
    return PS2_PAUSE_TAIL[pos +: 8];
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo
//   Generic single-clock FIFO.  A push while full is accepted only when a
//   pop happens in the same cycle; otherwise it is ignored (the caller
//   detects that through 'full').  pop_data always shows the head entry.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push, push_data     write request and entry
//   full                all DEPTH entries occupied
//   pop                 remove head (ignored when empty)
//   pop_data, empty     head entry, no entries present
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             wr_en_s;
  logic             rd_en_s;

  assign empty    = (count_r == '0);
  assign full     = (count_r == CW'(DEPTH));
  assign rd_en_s  = pop && !empty;
  assign wr_en_s  = push && (!full || rd_en_s);
  assign pop_data = mem_r[rd_ptr_r];

  // Storage, pointers (wrap naturally at DEPTH) and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Assembles the PS/2 Set-2 byte stream into key events (E0 extended and
//   F0 break prefixes, 8-byte Pause), abandons stale partial sequences after
//   TIMEOUT_CYCLES idle cycles and queues events in a small FIFO.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   data, new_data                  received byte and its one-cycle strobe
//   ev_code/ev_extended/ev_released FIFO head event
//   ev_valid, ev_ready              head valid / consumer accept
//   seq_error                       one-cycle pulse: timeout or Pause mismatch
//   overflow                        sticky: an event was dropped (FIFO full)
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       new_data,
  output logic [7:0] ev_code,
  output logic       ev_extended,
  output logic       ev_released,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       seq_error,
  output logic       overflow
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The timeout fires in the cycle whose increment would reach TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  dec_state_e       state_r, state_nxt_s;
  logic [2:0]       idx_r, idx_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             seq_error_r, err_nxt_s;
  logic             overflow_r;
  logic             push_s;
  ps2_event_t       push_ev_s;
  ps2_event_t       head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             pop_s;

  assign ev_valid    = !fifo_empty_s;
  assign pop_s       = ev_valid && ev_ready;
  assign ev_code     = head_s.code;
  assign ev_extended = head_s.extended;
  assign ev_released = head_s.released;
  assign seq_error   = seq_error_r;
  assign overflow    = overflow_r;

  // Next-state decode: a received byte always takes priority over the timeout.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    cnt_nxt_s   = cnt_r;
    err_nxt_s   = 1'b0;
    push_s      = 1'b0;
    push_ev_s   = make_event(1'b0, 1'b0, data);
    if (new_data) begin
      cnt_nxt_s = '0;
      case (state_r)
        ST_IDLE: begin
          if (data == PS2_EXT) begin
            state_nxt_s = ST_EXT;
          end else if (data == PS2_BRK) begin
            state_nxt_s = ST_BRK;
          end else if (data == PS2_PAUSE) begin
            state_nxt_s = ST_PAUSE;
            idx_nxt_s   = 3'd1;
          end else if (is_ignored(data)) begin
            state_nxt_s = ST_IDLE;
          end else begin
            push_s = 1'b1;
          end
        end
        ST_EXT: begin
          if (data == PS2_BRK) begin
            state_nxt_s = ST_EXT_BRK;
          end else if (data == PS2_EXT) begin
            state_nxt_s = ST_EXT;
          end else begin
            push_s      = 1'b1;
            push_ev_s   = make_event(1'b1, 1'b0, data);
            state_nxt_s = ST_IDLE;
          end
        end
        ST_BRK: begin
          push_s      = 1'b1;
          push_ev_s   = make_event(1'b0, 1'b1, data);
          state_nxt_s = ST_IDLE;
        end
        ST_EXT_BRK: begin
          push_s      = 1'b1;
          push_ev_s   = make_event(1'b1, 1'b1, data);
          state_nxt_s = ST_IDLE;
        end
        ST_PAUSE: begin
          if (data != pause_expected(idx_r)) begin
            // The offending byte is consumed, not re-decoded from IDLE.
            err_nxt_s   = 1'b1;
            state_nxt_s = ST_IDLE;
            idx_nxt_s   = 3'd0;
          end else if (idx_r == 3'd7) begin
            push_s      = 1'b1;
            push_ev_s   = make_event(1'b1, 1'b0, 8'h77);
            state_nxt_s = ST_IDLE;
            idx_nxt_s   = 3'd0;
          end else begin
            idx_nxt_s = idx_r + 3'd1;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          idx_nxt_s   = 3'd0;
        end
      endcase
    end else if (state_r == ST_IDLE) begin
      cnt_nxt_s = '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_nxt_s   = '0;
      err_nxt_s   = 1'b1;
      state_nxt_s = ST_IDLE;
      idx_nxt_s   = 3'd0;
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end
  end

  // Decoder state, Pause index, timeout counter and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      idx_r       <= 3'd0;
      cnt_r       <= '0;
      seq_error_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      idx_r       <= idx_nxt_s;
      cnt_r       <= cnt_nxt_s;
      seq_error_r <= err_nxt_s;
      if (push_s && fifo_full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  ps2_event_fifo #(
    .WIDTH (PS2_EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_ev_s),
    .full      (fifo_full_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .empty     (fifo_empty_s)
  );

endmodule
